// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with a start/done handshake.
// Single-cycle ops finish on the accepting edge. MUL runs a WIDTH-iteration
// shift-add loop. R and the flags hold their values between completions.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             Zero_Flag,
  output logic             Carry_Flag,
  output logic             Overflow_Flag
);

  localparam int         CNT_W  = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_next;
  logic [WIDTH-1:0]     mplier;
  logic                 accept_alu, accept_mul, mul_last;
  logic [WIDTH+1:0]     alu_res;

  // Single-cycle op evaluation, packed as {carry, overflow, result}.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]          ext;
    logic [WIDTH-1:0]        r;
    logic                    c, v;
    a_s = a;
    b_s = b;
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SLT: r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  assign alu_res  = alu_eval(ALU_Sel, A, B);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign busy     = (state == S_MUL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and accept/finish decode.
  always_comb begin
    state_next = state;
    accept_alu = 1'b0;
    accept_mul = 1'b0;
    mul_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (ALU_Sel == OP_MUL) begin
            accept_mul = 1'b1;
            state_next = S_MUL;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt == CNT_W'(1)) begin
          mul_last   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Multiplier datapath: operand load on accept, one shift-add per cycle.
  always_ff @(posedge clk) begin
    if (accept_mul) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Iteration counter, completion pulse and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      done          <= 1'b0;
      R             <= '0;
      Zero_Flag     <= 1'b0;
      Carry_Flag    <= 1'b0;
      Overflow_Flag <= 1'b0;
    end else begin
      done <= accept_alu | mul_last;
      if (accept_mul)          cnt <= CNT_W'(WIDTH);
      else if (state == S_MUL) cnt <= cnt - CNT_W'(1);
      if (accept_alu) begin
        R             <= alu_res[WIDTH-1:0];
        Zero_Flag     <= (alu_res[WIDTH-1:0] == '0);
        Carry_Flag    <= alu_res[WIDTH+1];
        Overflow_Flag <= alu_res[WIDTH];
      end else if (mul_last) begin
        R             <= acc_next[WIDTH-1:0];
        Zero_Flag     <= (acc_next[WIDTH-1:0] == '0);
        Carry_Flag    <= 1'b0;
        Overflow_Flag <= |acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: back-to-back single-cycle table plus MUL and
// reset corner sequences.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  A, B;
  logic [2:0]    ALU_Sel;
  logic          busy, done;
  logic [W-1:0]  R;
  logic          Zero_Flag, Carry_Flag, Overflow_Flag;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .busy(busy), .done(done), .R(R), .Zero_Flag(Zero_Flag),
    .Carry_Flag(Carry_Flag), .Overflow_Flag(Overflow_Flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] r, input logic z,
                         input logic c, input logic v, input logic d);
    chk({name, ".R"}, 64'(R), 64'(r));
    chk({name, ".Zero"}, 64'(Zero_Flag), 64'(z));
    chk({name, ".Carry"}, 64'(Carry_Flag), 64'(c));
    chk({name, ".Ovf"}, 64'(Overflow_Flag), 64'(v));
    chk({name, ".done"}, 64'(done), 64'(d));
  endtask

  // Waits for a MUL issued at the previous negedge to finish; returns the
  // number of negedges (counted from the accept edge) until done was seen.
  task automatic wait_done(input int limit, output int when);
    when = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        when = c;
        break;
      end
    end
  endtask

  int       when;
  int       pulses;
  logic [W-1:0] held;

  initial begin
    vecs[0]  = '{3'b000, 32'd10,         32'd5,          32'd15,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'd20,         32'd15,         32'd5,          1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b000, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'b010, 32'd12,         32'd7,          32'd4,          1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 32'd6,          32'd3,          32'd7,          1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 32'd6,          32'd3,          32'd5,          1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b100, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; ALU_Sel = '0;
    repeat (3) @(negedge clk);
    chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Single-cycle ops issued on consecutive cycles; done expected every cycle.
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0)
        chk_out($sformatf("vec%0d", i - 1), vecs[i-1].r, vecs[i-1].z,
                vecs[i-1].c, vecs[i-1].v, 1'b1);
      if (i < 12) begin
        start = 1'b1; ALU_Sel = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle.done", 64'(done), 64'd0);
    held = R;

    // MUL 7*3 with an ignored start while busy.
    start = 1'b1; ALU_Sel = 3'b110; A = 32'd7; B = 32'd3;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    chk("mul1.busy", 64'(busy), 64'd1);
    chk("mul1.nodone", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    start = 1'b1; ALU_Sel = 3'b000; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mul1.held", 64'(R), 64'(held));
    chk("mul1.busy_mid", 64'(busy), 64'd1);
    wait_done(40, when);
    when = when + 7;
    chk("mul1.latency", 64'(when), 64'd33);
    chk_out("mul1", 32'd21, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mul1.busy_end", 64'(busy), 64'd0);

    // Second MUL issued in the done cycle.
    start = 1'b1; ALU_Sel = 3'b110; A = 32'h10000; B = 32'h10000;
    @(negedge clk);
    start = 1'b0;
    chk("mul2.busy", 64'(busy), 64'd1);
    chk("mul2.done_single", 64'(done), 64'd0);
    wait_done(40, when);
    chk("mul2.latency", 64'(when + 1), 64'd33);
    chk_out("mul2", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset 10 cycles into a MUL aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; ALU_Sel = 3'b110; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("abort", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.busy", 64'(busy), 64'd0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort.no_done", 64'(pulses), 64'd0);
    start = 1'b1; ALU_Sel = 3'b000; A = 32'd1; B = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk_out("add_after_abort", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
